captura_operandos: RTL and testbench
====================================

# captura_operandos

Keypad entry stage directly upstream of the restoring divider. It turns a stream of debounced key codes into the two BCD operands `{decenas, unidades}` and a one-cycle `start` pulse. It then holds the operands stable while the divider runs and flags when the divider's quotient and remainder outputs are final. Operands are limited to 0..15, the divider's 4-bit range.

## Interface
- `DIV_LAT`, default 5: cycles from the `start` cycle until divider outputs are final (start cycle plus 4 iterations).
- `clk`  in  1  system clock; every register is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `key_valid`  in  1  one-cycle strobe; `key_code` is valid this cycle.
- `key_code`  in  4  0x0–0x9 digit, 0xA ENTER, 0xB CLEAR; 0xC–0xF ignored silently.
- `a_bcd`  out  8  dividend `{decenas, unidades}`; empty digit = 4'hF.
- `b_bcd`  out  8  divisor, same encoding.
- `start`  out  1  one-cycle pulse to the divider.
- `listo`  out  1  high while divider outputs are final and valid.
- `err`  out  1  one-cycle pulse on each rejected key.
- `fase`  out  2  current state: 0 CAP_A, 1 CAP_B, 2 ESPERA, 3 LISTO.

## Operation
- States: CAP_A, CAP_B, ESPERA, LISTO. Each operand has a 2-bit digit count `n` (0..2).
- **Reset values:** `a_bcd` = `b_bcd` = 8'hFF; `start` = `listo` = `err` = 0; state CAP_A; digit counts 0; wait counter 0.
- **Digit key in CAP_A or CAP_B** updates the active operand:
  - `n`=0: `{F, d}`, `n`←1.
  - `n`=1 with current units `u`: new value is `u*10+d`. If that value ≤15, the operand becomes `{u, d}` and `n`←2. Otherwise reject.
  - `n`=2: reject.
  - Leading zero is legal: `0` then `7` gives `{0, 7}`.
- **Reject:** `err` pulses and all state is unchanged.
- **ENTER in CAP_A:** if `n`=0, reject. Otherwise go to CAP_B.
- **ENTER in CAP_B:** reject if `n`=0 or the divisor value is 0. Otherwise pulse `start` and go to ESPERA with the counter cleared.
- **ESPERA:**
  - All keys are dropped with no `err`.
  - `a_bcd` and `b_bcd` must not change, because the divider samples them combinationally on every iteration.
  - The counter increments each cycle. When it reaches `DIV_LAT`-1, go to LISTO.
- **LISTO:**
  - `listo` is held high.
  - A digit key resets both operands to 8'hFF and loads the digit into A (`n`=1). State goes to CAP_A and `listo` drops.
  - ENTER is rejected.
  - CLEAR behaves as in any other state.
- **CLEAR in CAP_A, CAP_B or LISTO:** operands to 8'hFF, counts to 0, state to CAP_A, `listo` to 0. CLEAR is ignored in ESPERA.
- **Value decode:** tens digit 1 counts as 10; tens 0 or F counts as 0; units F counts as 0. Tens digits other than 0, 1 and F are never produced.
- `key_valid` is assumed single-cycle. Back-to-back strobes are each processed in their own cycle.

## Timing
- Key effects are registered: a key strobed in cycle t is visible on the outputs at t+1.
- `start` is high exactly one cycle, at t+1 after the accepted ENTER.
- `listo` rises `DIV_LAT` cycles after `start` rises. It stays high until a digit key, CLEAR, or reset.
- `err` is high exactly at t+1 after the rejected key.
- Reset mid-operation:
  - Asserting `rst_n` low forces all reset values immediately, including during ESPERA.
  - The divider shares `rst_n`, so no stale `start` pulse survives.

## Structure
- Shared package `calc_pkg`:
  - state enum `fase_t`;
  - key constants `KEY_ENTER` = 4'hA and `KEY_CLEAR` = 4'hB;
  - `BCD_VACIO` = 4'hF;
  - `OP_MAX` = 15.
- Single module with no sub-module. The per-operand digit logic is a small function (BCD pair to 0..15 value) placed in `calc_pkg` for reuse by the display path.
- Expected size: 150–250 lines.

## Test plan
- Enter `1,2,ENTER,5,ENTER`:
  - `a_bcd`=8'h12 and `b_bcd`=8'hF5;
  - `start` pulses once;
  - `listo` rises exactly 5 cycles later;
  - a divider stub reads quotient 2, remainder 2.
- Enter `1,7`:
  - 2nd key rejected, `err` pulses, `a_bcd` stays 8'hF1;
  - then `1,5,9`: the 9 is rejected and `a_bcd` is 8'h15.
- Enter `8,ENTER,0,ENTER`:
  - the second ENTER is rejected (divisor 0) with `err`;
  - no `start`, `fase` stays 1.
- During ESPERA, send CLEAR and digit 3:
  - no change to `a_bcd`/`b_bcd`;
  - no `err`;
  - `listo` still rises on schedule.
- In LISTO, send digit 4:
  - `a_bcd`=8'hF4 and `b_bcd`=8'hFF;
  - `fase`=0 and `listo`=0 the next cycle.
- Assert `rst_n` low two cycles after `start`:
  - all outputs return to reset values asynchronously;
  - `listo` never rises.

Source files
------------

// File: rtl/calc_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the keypad calculator front end: the capture FSM
// phase encoding, the special key codes, the empty-digit marker and the
// helper that turns a BCD operand pair into its 0..15 value. The display
// path reuses bcd_valor, so keep it free of any state.
// ---------------------------------------------------------------------------
package calc_pkg;

    // Capture phases, encoded exactly as they appear on the fase output
    typedef enum logic [1:0] {
        CAP_A  = 2'd0,
        CAP_B  = 2'd1,
        ESPERA = 2'd2,
        LISTO  = 2'd3
    } fase_t;

    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_CLEAR = 4'hB;
    localparam logic [3:0] BCD_VACIO = 4'hF;
    localparam int         OP_MAX    = 15;

    // True for the ten digit keys 0..9
    function automatic logic es_digito(input logic [3:0] codigo);
        return (codigo <= 4'd9);
    endfunction

    // BCD pair {decenas, unidades} to its numeric value. Only 0, 1 and the
    // empty marker ever appear as tens digit, so a tens of 1 means ten and
    // anything else contributes nothing. An empty units digit counts as 0.
    function automatic logic [4:0] bcd_valor(input logic [7:0] par);
        logic [4:0] decenas;
        logic [4:0] unidades;
        decenas  = (par[7:4] == 4'd1) ? 5'd10 : 5'd0;
        unidades = (par[3:0] == BCD_VACIO) ? 5'd0 : {1'b0, par[3:0]};
        return decenas + unidades;
    endfunction

endpackage : calc_pkg

// File: rtl/captura_operandos.sv
// ---------------------------------------------------------------------------
// captura_operandos
// Keypad entry stage in front of the restoring divider. Debounced key codes
// build the dividend (A) and divisor (B) as BCD pairs, an accepted ENTER on
// the divisor fires a one-cycle start pulse, the operands are then frozen
// while the divider iterates, and listo reports when its results are final.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   key_valid  one-cycle strobe qualifying key_code
//   key_code   0..9 digit, A ENTER, B CLEAR, C..F silently ignored
//   a_bcd      dividend {decenas, unidades}, F marks an empty digit
//   b_bcd      divisor, same encoding
//   start      one-cycle pulse to the divider
//   listo      high while divider outputs are final
//   err        one-cycle pulse for every rejected key
//   fase       current phase (0 CAP_A, 1 CAP_B, 2 ESPERA, 3 LISTO)
// ---------------------------------------------------------------------------
module captura_operandos
    import calc_pkg::*;
#(
    parameter int DIV_LAT = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [7:0] a_bcd,
    output logic [7:0] b_bcd,
    output logic       start,
    output logic       listo,
    output logic       err,
    output logic [1:0] fase
);

    localparam int CNT_W = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_FIN = CNT_W'(DIV_LAT - 1);

    fase_t            fase_q, fase_d;
    logic [7:0]       a_q, a_d;
    logic [7:0]       b_q, b_d;
    logic [1:0]       na_q, na_d;
    logic [1:0]       nb_q, nb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start_q, start_d;
    logic             err_q, err_d;

    logic [7:0]       op_act;
    logic [1:0]       n_act;
    logic [6:0]       valor_dos;
    logic             dig_ok;
    logic [7:0]       op_nuevo;
    logic [1:0]       n_nuevo;

    // The digit logic is shared by both operands: pick whichever one the
    // current phase is filling. Outside CAP_B this is always A, which is
    // harmless because digits are only applied in CAP_A/CAP_B.
    assign op_act = (fase_q == CAP_B) ? b_q : a_q;
    assign n_act  = (fase_q == CAP_B) ? nb_q : na_q;

    // Value the operand would take if the incoming digit became the new
    // units digit. The held units digit is always a real digit when n=1,
    // so the product never exceeds 99 and fits in 7 bits.
    assign valor_dos = ({3'b000, op_act[3:0]} * 7'd10) + {3'b000, key_code};

    // Decide whether a digit key can be appended to the active operand and
    // what the operand and its digit count become if it is.
    always_comb begin
        dig_ok   = 1'b0;
        op_nuevo = op_act;
        n_nuevo  = n_act;
        case (n_act)
            2'd0: begin
                dig_ok   = 1'b1;
                op_nuevo = {BCD_VACIO, key_code};
                n_nuevo  = 2'd1;
            end
            2'd1: begin
                if (valor_dos <= 7'(OP_MAX)) begin
                    dig_ok   = 1'b1;
                    op_nuevo = {op_act[3:0], key_code};
                    n_nuevo  = 2'd2;
                end
            end
            default: begin
                dig_ok = 1'b0;
            end
        endcase
    end

    // Next-state logic for the whole capture stage. A rejected key only
    // raises err; every other register keeps its value. While the divider
    // runs (ESPERA) keys are dropped without err so the operands it reads
    // combinationally stay frozen, and only the latency counter moves.
    always_comb begin
        fase_d  = fase_q;
        a_d     = a_q;
        b_d     = b_q;
        na_d    = na_q;
        nb_d    = nb_q;
        cnt_d   = cnt_q;
        start_d = 1'b0;
        err_d   = 1'b0;

        case (fase_q)
            CAP_A, CAP_B: begin
                if (key_valid) begin
                    if (es_digito(key_code)) begin
                        if (!dig_ok) begin
                            err_d = 1'b1;
                        end else if (fase_q == CAP_A) begin
                            a_d  = op_nuevo;
                            na_d = n_nuevo;
                        end else begin
                            b_d  = op_nuevo;
                            nb_d = n_nuevo;
                        end
                    end else if (key_code == KEY_ENTER) begin
                        if (fase_q == CAP_A) begin
                            if (na_q == 2'd0) begin
                                err_d = 1'b1;
                            end else begin
                                fase_d = CAP_B;
                            end
                        end else begin
                            // A zero divisor would make the divider
                            // meaningless, so it is refused here.
                            if ((nb_q == 2'd0) || (bcd_valor(b_q) == 5'd0)) begin
                                err_d = 1'b1;
                            end else begin
                                start_d = 1'b1;
                                cnt_d   = '0;
                                fase_d  = ESPERA;
                            end
                        end
                    end else if (key_code == KEY_CLEAR) begin
                        a_d    = 8'hFF;
                        b_d    = 8'hFF;
                        na_d   = 2'd0;
                        nb_d   = 2'd0;
                        fase_d = CAP_A;
                    end
                end
            end

            ESPERA: begin
                // The start cycle counts as cycle 0, so after DIV_LAT-1
                // further cycles the divider has finished its iterations.
                if (cnt_q == CNT_FIN) begin
                    fase_d = LISTO;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            LISTO: begin
                if (key_valid) begin
                    if (es_digito(key_code)) begin
                        // A digit starts a fresh calculation with this
                        // digit already entered as the dividend.
                        a_d    = {BCD_VACIO, key_code};
                        b_d    = 8'hFF;
                        na_d   = 2'd1;
                        nb_d   = 2'd0;
                        fase_d = CAP_A;
                    end else if (key_code == KEY_ENTER) begin
                        err_d = 1'b1;
                    end else if (key_code == KEY_CLEAR) begin
                        a_d    = 8'hFF;
                        b_d    = 8'hFF;
                        na_d   = 2'd0;
                        nb_d   = 2'd0;
                        fase_d = CAP_A;
                    end
                end
            end

            default: begin
                fase_d = CAP_A;
            end
        endcase
    end

    // State registers. The divider shares rst_n, so clearing start here
    // along with everything else guarantees no stale pulse reaches it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fase_q  <= CAP_A;
            a_q     <= 8'hFF;
            b_q     <= 8'hFF;
            na_q    <= 2'd0;
            nb_q    <= 2'd0;
            cnt_q   <= '0;
            start_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            fase_q  <= fase_d;
            a_q     <= a_d;
            b_q     <= b_d;
            na_q    <= na_d;
            nb_q    <= nb_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            err_q   <= err_d;
        end
    end

    assign a_bcd = a_q;
    assign b_bcd = b_q;
    assign start = start_q;
    assign err   = err_q;
    assign listo = (fase_q == LISTO);
    assign fase  = fase_q;

endmodule : captura_operandos

// File: tb/tb_captura_operandos.sv
// ---------------------------------------------------------------------------
// tb_captura_operandos
// Directed keypad sequences against captura_operandos. A value-level model
// (digit count plus numeric value per operand, a phase number and the cycle
// at which start fired) predicts every output, and a compare process checks
// the DUT against it on each falling edge. Literal expectations taken from
// worked examples pin the model itself.
// ---------------------------------------------------------------------------
module tb_captura_operandos;

    localparam int DIV_LAT = 5;
    localparam logic [3:0] K_ENTER = 4'hA;
    localparam logic [3:0] K_CLEAR = 4'hB;

    logic       clk;
    logic       rst_n;
    logic       key_valid;
    logic [3:0] key_code;
    logic [7:0] a_bcd;
    logic [7:0] b_bcd;
    logic       start;
    logic       listo;
    logic       err;
    logic [1:0] fase;

    int compared = 0;
    int failed   = 0;

    // Model state: phase 0..3, digit count and value of each operand
    int mPhase = 0;
    int mNa = 0, mVa = 0;
    int mNb = 0, mVb = 0;
    int mCycle = 0;
    int mStartCycle = 0;
    bit mStart = 1'b0;
    bit mErr = 1'b0;

    captura_operandos #(.DIV_LAT(DIV_LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_code  (key_code),
        .a_bcd     (a_bcd),
        .b_bcd     (b_bcd),
        .start     (start),
        .listo     (listo),
        .err       (err),
        .fase      (fase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record one comparison and report it if it does not hold
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Strobe one key for exactly one cycle; call on a falling edge
    task automatic applyStimulus(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    // Count falling edges until listo is seen, bounded
    task automatic waitListo(input int yaPasados, output int lat);
        lat = -1;
        for (int i = yaPasados + 1; i <= yaPasados + 30; i++) begin
            @(negedge clk);
            if (listo === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    // BCD pair an operand must show given its digit count and value
    function automatic logic [7:0] expOp(input int n, input int v);
        if (n == 0) return 8'hFF;
        if (n == 1) return {4'hF, 4'(v)};
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    // Independent decode used by the divider stub
    function automatic int valorDe(input logic [7:0] p);
        int t, u;
        t = (p[7:4] == 4'h1) ? 10 : 0;
        u = (p[3:0] == 4'hF) ? 0 : int'(p[3:0]);
        return t + u;
    endfunction

    task automatic modelClear();
        mPhase = 0;
        mNa = 0; mVa = 0;
        mNb = 0; mVb = 0;
    endtask

    // Apply one key to the model according to the calculator rules
    task automatic modelKey(input logic [3:0] k);
        int d;
        d = int'(k);
        if (mPhase == 3) begin
            if (d <= 9) begin
                mNa = 1; mVa = d;
                mNb = 0; mVb = 0;
                mPhase = 0;
            end else if (k == K_ENTER) begin
                mErr = 1'b1;
            end else if (k == K_CLEAR) begin
                modelClear();
            end
        end else if (d <= 9) begin
            int n, v;
            n = (mPhase == 0) ? mNa : mNb;
            v = (mPhase == 0) ? mVa : mVb;
            if (n == 0) begin
                n = 1; v = d;
            end else if (n == 1 && v * 10 + d <= 15) begin
                n = 2; v = v * 10 + d;
            end else begin
                mErr = 1'b1;
            end
            if (mPhase == 0) begin mNa = n; mVa = v; end
            else begin mNb = n; mVb = v; end
        end else if (k == K_ENTER) begin
            if (mPhase == 0) begin
                if (mNa == 0) mErr = 1'b1;
                else mPhase = 1;
            end else begin
                if (mNb == 0 || mVb == 0) mErr = 1'b1;
                else begin
                    mStart = 1'b1;
                    mPhase = 2;
                    mStartCycle = mCycle;
                end
            end
        end else if (k == K_CLEAR) begin
            modelClear();
        end
    endtask

    // Model update on every rising edge, reset asynchronously
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                modelClear();
                mStart = 1'b0;
                mErr = 1'b0;
            end else begin
                mCycle++;
                mStart = 1'b0;
                mErr = 1'b0;
                if (mPhase == 2) begin
                    if (mCycle == mStartCycle + DIV_LAT) mPhase = 3;
                end else if (key_valid) begin
                    modelKey(key_code);
                end
            end
        end
    end

    // Compare every output against the model each cycle
    initial begin
        forever begin
            @(negedge clk);
            checkOutput("a_bcd", 32'(a_bcd), 32'(expOp(mNa, mVa)));
            checkOutput("b_bcd", 32'(b_bcd), 32'(expOp(mNb, mVb)));
            checkOutput("start", 32'(start), 32'(mStart));
            checkOutput("err", 32'(err), 32'(mErr));
            checkOutput("listo", 32'(listo), 32'(mPhase == 3));
            checkOutput("fase", 32'(fase), 32'(mPhase));
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int av, bv;
        rst_n = 1'b0;
        key_valid = 1'b0;
        key_code = 4'h0;
        repeat (2) @(negedge clk);
        checkOutput("reset a_bcd", 32'(a_bcd), 32'h0FF);
        checkOutput("reset b_bcd", 32'(b_bcd), 32'h0FF);
        checkOutput("reset start", 32'(start), 32'h0);
        checkOutput("reset listo", 32'(listo), 32'h0);
        checkOutput("reset err", 32'(err), 32'h0);
        checkOutput("reset fase", 32'(fase), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] 1,2,ENTER,5,ENTER");
        applyStimulus(4'd1);
        applyStimulus(4'd2);
        checkOutput("A=12", 32'(a_bcd), 32'h12);
        applyStimulus(K_ENTER);
        checkOutput("fase CAP_B", 32'(fase), 32'd1);
        applyStimulus(4'd5);
        applyStimulus(K_ENTER);
        checkOutput("B=F5", 32'(b_bcd), 32'hF5);
        checkOutput("start pulse", 32'(start), 32'd1);
        checkOutput("fase ESPERA", 32'(fase), 32'd2);
        waitListo(0, lat);
        checkOutput("listo latency", 32'(lat), 32'd5);
        av = valorDe(a_bcd);
        bv = valorDe(b_bcd);
        checkOutput("stub quotient", 32'((bv != 0) ? av / bv : -1), 32'd2);
        checkOutput("stub remainder", 32'((bv != 0) ? av % bv : -1), 32'd2);

        $display("[TB] digit in LISTO");
        applyStimulus(4'd4);
        checkOutput("LISTO digit A", 32'(a_bcd), 32'hF4);
        checkOutput("LISTO digit B", 32'(b_bcd), 32'hFF);
        checkOutput("LISTO digit fase", 32'(fase), 32'd0);
        checkOutput("LISTO digit listo", 32'(listo), 32'd0);

        $display("[TB] range limits");
        applyStimulus(K_CLEAR);
        applyStimulus(4'd1);
        applyStimulus(4'd7);
        checkOutput("17 err", 32'(err), 32'd1);
        checkOutput("17 A", 32'(a_bcd), 32'hF1);
        applyStimulus(K_CLEAR);
        applyStimulus(4'd1);
        applyStimulus(4'd5);
        applyStimulus(4'd9);
        checkOutput("third digit err", 32'(err), 32'd1);
        checkOutput("A=15", 32'(a_bcd), 32'h15);

        $display("[TB] zero divisor");
        applyStimulus(K_CLEAR);
        applyStimulus(4'd8);
        applyStimulus(K_ENTER);
        applyStimulus(4'd0);
        applyStimulus(K_ENTER);
        checkOutput("div0 err", 32'(err), 32'd1);
        checkOutput("div0 start", 32'(start), 32'd0);
        checkOutput("div0 fase", 32'(fase), 32'd1);

        $display("[TB] keys during ESPERA");
        applyStimulus(K_CLEAR);
        applyStimulus(4'd9);
        applyStimulus(K_ENTER);
        applyStimulus(4'd3);
        applyStimulus(K_ENTER);
        applyStimulus(K_CLEAR);
        applyStimulus(4'd3);
        checkOutput("ESPERA A", 32'(a_bcd), 32'hF9);
        checkOutput("ESPERA B", 32'(b_bcd), 32'hF3);
        checkOutput("ESPERA err", 32'(err), 32'd0);
        waitListo(2, lat);
        checkOutput("ESPERA listo latency", 32'(lat), 32'd5);
        applyStimulus(K_ENTER);
        checkOutput("LISTO ENTER err", 32'(err), 32'd1);
        checkOutput("LISTO ENTER fase", 32'(fase), 32'd3);
        applyStimulus(4'hC);
        checkOutput("ignored key err", 32'(err), 32'd0);
        applyStimulus(K_CLEAR);
        checkOutput("LISTO CLEAR fase", 32'(fase), 32'd0);

        $display("[TB] leading zero and CLEAR in CAP_B");
        applyStimulus(4'd0);
        applyStimulus(4'd7);
        checkOutput("A=07", 32'(a_bcd), 32'h07);
        applyStimulus(K_ENTER);
        applyStimulus(4'd2);
        applyStimulus(K_CLEAR);
        checkOutput("CAP_B CLEAR fase", 32'(fase), 32'd0);
        checkOutput("CAP_B CLEAR B", 32'(b_bcd), 32'hFF);

        $display("[TB] reset during ESPERA");
        applyStimulus(4'd6);
        applyStimulus(K_ENTER);
        applyStimulus(4'd2);
        applyStimulus(K_ENTER);
        checkOutput("pre-reset start", 32'(start), 32'd1);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async reset A", 32'(a_bcd), 32'h0FF);
        checkOutput("async reset B", 32'(b_bcd), 32'h0FF);
        checkOutput("async reset start", 32'(start), 32'd0);
        checkOutput("async reset fase", 32'(fase), 32'd0);
        checkOutput("async reset listo", 32'(listo), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("no listo after reset", 32'(listo), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule : tb_captura_operandos
